mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 102 ++++++++++
 tb/tb_mem_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares one unified memory port between instruction fetch and data access.
// Data normally wins contention; a saturating loss counter hands the port to a starved fetch.
module mem_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ready,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   output logic [31:0] dm_rdata,
   output logic        dm_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        stall_f,
   output logic        stall_m
);

   typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} stateT;

   stateT      state;
   logic [2:0] starveCnt;
   logic       ifEff;
   logic       dmEff;
   logic       fetchWins;

   // A request in its own ready cycle is the one just served, so it is masked.
   assign ifEff     = if_req & ~if_ready;
   assign dmEff     = dm_req & ~dm_ready;
   assign fetchWins = ifEff & (~dmEff | (32'(starveCnt) >= STARVE_LIMIT));
   assign stall_f   = ifEff;
   assign stall_m   = dmEff;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= StIdle;
         starveCnt <= 3'd0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= 32'd0;
         mem_wdata <= 32'd0;
         if_ready  <= 1'b0;
         dm_ready  <= 1'b0;
         if_rdata  <= 32'd0;
         dm_rdata  <= 32'd0;
      end else begin
         if_ready <= 1'b0;
         dm_ready <= 1'b0;
         case (state)
            StIdle: begin
               if (fetchWins) begin
                  state     <= StBusyI;
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b0;
                  mem_addr  <= if_addr;
                  mem_wdata <= dm_wdata;
                  starveCnt <= 3'd0;
               end else if (dmEff) begin
                  state     <= StBusyD;
                  mem_req   <= 1'b1;
                  mem_we    <= dm_we;
                  mem_addr  <= dm_addr;
                  mem_wdata <= dm_wdata;
                  if (ifEff && starveCnt != 3'd7) begin
                     starveCnt <= starveCnt + 3'd1;
                  end
               end
            end
            StBusyI: begin
               if (mem_ack) begin
                  state    <= StIdle;
                  mem_req  <= 1'b0;
                  if_rdata <= mem_rdata;
                  if_ready <= 1'b1;
               end
            end
            StBusyD: begin
               if (mem_ack) begin
                  state    <= StIdle;
                  mem_req  <= 1'b0;
                  dm_rdata <= mem_rdata;
                  dm_ready <= 1'b1;
               end
            end
            default: begin
               state   <= StIdle;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_mem_arbiter;

   localparam int Limit = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req, dm_req, dm_we, mem_ack;
   logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
   logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
   logic        if_ready, dm_ready, mem_req, mem_we, stall_f, stall_m;

   int nRun  = 0;
   int nFail = 0;

   mem_arbiter #(.STARVE_LIMIT(Limit)) dut (
      .clk       (clk),
      .reset     (reset),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_rdata  (if_rdata),
      .if_ready  (if_ready),
      .dm_req    (dm_req),
      .dm_we     (dm_we),
      .dm_addr   (dm_addr),
      .dm_wdata  (dm_wdata),
      .dm_rdata  (dm_rdata),
      .dm_ready  (dm_ready),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .stall_f   (stall_f),
      .stall_m   (stall_m)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b1; mem_ack = 1'b1;
      if_addr = $urandom; dm_addr = $urandom; dm_wdata = $urandom; mem_rdata = $urandom;
      tick(); tick();
      nRun++; if ({mem_req, mem_we, if_ready, dm_ready} !== 4'b0) begin nFail++;
         $display("FAIL reset_flags: got %b want 0000", {mem_req, mem_we, if_ready, dm_ready}); end
      nRun++; if (mem_addr !== 32'd0) begin nFail++;
         $display("FAIL reset_addr: got %h want 0", mem_addr); end
      nRun++; if (mem_wdata !== 32'd0) begin nFail++;
         $display("FAIL reset_wdata: got %h want 0", mem_wdata); end
      nRun++; if ({if_rdata, dm_rdata} !== 64'd0) begin nFail++;
         $display("FAIL reset_rdata: got %h/%h want 0/0", if_rdata, dm_rdata); end
      if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; mem_ack = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      nRun++; if (mem_req !== 1'b0) begin nFail++;
         $display("FAIL reset_idle: mem_req got %b want 0", mem_req); end
   endtask

   task automatic test_lone_fetch();
      if_req = 1'b1; if_addr = 32'h40; dm_wdata = 32'h0;
      tick();
      nRun++; if ({mem_req, mem_we, if_ready, stall_f} !== 4'b1001) begin nFail++;
         $display("FAIL fetch_grant: req/we/rdy/stall got %b want 1001",
                  {mem_req, mem_we, if_ready, stall_f}); end
      nRun++; if (mem_addr !== 32'h40) begin nFail++;
         $display("FAIL fetch_addr: got %h want 40", mem_addr); end
      mem_ack = 1'b1; mem_rdata = 32'h2008_0005;
      tick();
      nRun++; if ({mem_req, if_ready, stall_f} !== 3'b010) begin nFail++;
         $display("FAIL fetch_done: req/rdy/stall got %b want 010", {mem_req, if_ready, stall_f}); end
      nRun++; if (if_rdata !== 32'h2008_0005) begin nFail++;
         $display("FAIL fetch_rdata: got %h want 20080005", if_rdata); end
      mem_ack = 1'b0; if_req = 1'b0; mem_rdata = 32'hffff_ffff;
      tick();
      nRun++; if ({mem_req, if_ready} !== 2'b00 || if_rdata !== 32'h2008_0005) begin nFail++;
         $display("FAIL fetch_after: req/rdy got %b rdata %h want 00 20080005",
                  {mem_req, if_ready}, if_rdata); end
   endtask

   task automatic test_store();
      int reqCycles = 0;
      int readyCnt  = 0;
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h54; dm_wdata = 32'd7; mem_rdata = 32'hdead_beef;
      for (int c = 0; c < 7; c++) begin
         tick();
         if (mem_req) reqCycles++;
         if (dm_ready) readyCnt++;
         nRun++; if (mem_req !== (c < 3) || dm_ready !== (c == 3)) begin nFail++;
            $display("FAIL store_seq c%0d: req/rdy got %b%b want %b%b", c, mem_req, dm_ready,
                     c < 3, c == 3); end
         nRun++; if (stall_m !== (c < 3)) begin nFail++;
            $display("FAIL store_stall c%0d: got %b want %b", c, stall_m, c < 3); end
         if (c < 3) begin
            nRun++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h54, 32'd7}) begin nFail++;
               $display("FAIL store_bus c%0d: we %b addr %h wdata %h want 1 54 7", c, mem_we,
                        mem_addr, mem_wdata); end
         end
         mem_ack = (c == 2);
         if (c == 3) begin dm_req = 1'b0; dm_we = 1'b0; end
      end
      nRun++; if (reqCycles != 3 || readyCnt != 1) begin nFail++;
         $display("FAIL store_counts: req cycles %0d ready %0d want 3 1", reqCycles, readyCnt); end
   endtask

   // The ready-cycle mask lets a pending fetch in after every data access, so grants alternate.
   task automatic test_contention();
      logic [31:0] want;
      if_req = 1'b1; if_addr = 32'h100; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
      for (int g = 0; g < 6; g++) begin
         want = (g % 2 == 0) ? 32'h200 : 32'h100;
         tick();
         nRun++; if (mem_req !== 1'b1 || mem_addr !== want) begin nFail++;
            $display("FAIL contend_grant%0d: req %b addr %h want 1 %h", g, mem_req, mem_addr, want); end
         mem_ack = 1'b1; mem_rdata = $urandom;
         tick();
         nRun++; if ({dm_ready, if_ready} !== ((g % 2 == 0) ? 2'b10 : 2'b01)) begin nFail++;
            $display("FAIL contend_ready%0d: dm/if got %b%b", g, dm_ready, if_ready); end
         mem_ack = 1'b0;
      end
      if_req = 1'b0; dm_req = 1'b0;
      tick(); tick();
   endtask

   task automatic test_masking();
      int grants = 0;
      int readies = 0;
      logic prevReq = 1'b0;
      logic dropNext = 1'b0;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (mem_req && !prevReq) grants++;
         prevReq = mem_req;
         if (dm_ready) readies++;
         mem_ack = mem_req;
         if (dropNext) dm_req = 1'b0;
         dropNext = dm_ready;
      end
      mem_ack = 1'b0;
      nRun++; if (grants != 1) begin nFail++;
         $display("FAIL mask_grants: got %0d want 1", grants); end
      nRun++; if (readies != 1) begin nFail++;
         $display("FAIL mask_ready: got %0d want 1", readies); end
   endtask

   task automatic test_reset_mid();
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h90;
      tick();
      nRun++; if (mem_req !== 1'b1) begin nFail++;
         $display("FAIL rstmid_grant: mem_req got %b want 1", mem_req); end
      reset = 1'b0;
      tick();
      nRun++; if ({mem_req, dm_ready} !== 2'b00) begin nFail++;
         $display("FAIL rstmid_abort: req/rdy got %b want 00", {mem_req, dm_ready}); end
      reset = 1'b1; dm_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
      tick();
      nRun++; if ({mem_req, dm_ready, if_ready} !== 3'b000 || dm_rdata !== 32'd0) begin nFail++;
         $display("FAIL rstmid_stray: req/drdy/irdy %b dm_rdata %h want 000 0",
                  {mem_req, dm_ready, if_ready}, dm_rdata); end
      mem_ack = 1'b0;
      tick();
      nRun++; if ({mem_req, dm_ready} !== 2'b00) begin nFail++;
         $display("FAIL rstmid_after: req/rdy got %b want 00", {mem_req, dm_ready}); end
   endtask

   task automatic test_random();
      int          mBusy, mStarve, memWait;   // mBusy: 0 none, 1 fetch, 2 data
      logic [31:0] mAddr, mWdata, mIfRdata, mDmRdata;
      logic        mWe, mIfReady, mDmReady, effI, effD, nIf, nDm, ifPend, dmPend;
      reset = 1'b0; if_req = 1'b0; dm_req = 1'b0; mem_ack = 1'b0;
      tick();
      reset = 1'b1;
      mBusy = 0; mStarve = 0; memWait = -1; mAddr = 0; mWdata = 0; mIfRdata = 0; mDmRdata = 0;
      mWe = 0; mIfReady = 0; mDmReady = 0; ifPend = 0; dmPend = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         effI = if_req && !mIfReady;
         effD = dm_req && !mDmReady;
         nIf = 1'b0; nDm = 1'b0;
         if (mBusy == 0) begin
            if (effD && !(effI && mStarve >= Limit)) begin
               mBusy = 2; mAddr = dm_addr; mWe = dm_we; mWdata = dm_wdata;
               if (effI && mStarve < 7) mStarve++;
            end else if (effI) begin
               mBusy = 1; mAddr = if_addr; mWe = 1'b0; mWdata = dm_wdata; mStarve = 0;
            end
         end else if (mem_ack) begin
            if (mBusy == 1) begin mIfRdata = mem_rdata; nIf = 1'b1; end
            else begin mDmRdata = mem_rdata; nDm = 1'b1; end
            mBusy = 0;
         end
         mIfReady = nIf; mDmReady = nDm;
         tick();
         nRun++; if (mem_req !== (mBusy != 0)) begin nFail++;
            $display("FAIL rnd_req @%0d: got %b want %b", cyc, mem_req, mBusy != 0); end
         nRun++; if ({mem_we, mem_addr, mem_wdata} !== {mWe, mAddr, mWdata}) begin nFail++;
            $display("FAIL rnd_bus @%0d: got %b %h %h want %b %h %h", cyc, mem_we, mem_addr,
                     mem_wdata, mWe, mAddr, mWdata); end
         nRun++; if ({if_ready, dm_ready} !== {mIfReady, mDmReady}) begin nFail++;
            $display("FAIL rnd_ready @%0d: got %b%b want %b%b", cyc, if_ready, dm_ready,
                     mIfReady, mDmReady); end
         nRun++; if ({if_rdata, dm_rdata} !== {mIfRdata, mDmRdata}) begin nFail++;
            $display("FAIL rnd_rdata @%0d: got %h %h want %h %h", cyc, if_rdata, dm_rdata,
                     mIfRdata, mDmRdata); end
         nRun++; if ({stall_f, stall_m} !== {if_req & ~mIfReady, dm_req & ~mDmReady}) begin
            nFail++;
            $display("FAIL rnd_stall @%0d: got %b%b", cyc, stall_f, stall_m); end
         if (mIfReady) ifPend = 1'b0;
         if (mDmReady) dmPend = 1'b0;
         if (!ifPend) begin
            if_addr = $urandom;
            ifPend = ($urandom_range(0, 3) == 0);
         end
         if (!dmPend) begin
            dm_addr = $urandom; dm_we = 1'($urandom_range(0, 1)); dm_wdata = $urandom;
            dmPend = ($urandom_range(0, 2) == 0);
         end
         if_req = ifPend; dm_req = dmPend;
         if (mBusy != 0) begin
            if (memWait < 0) memWait = $urandom_range(0, 3);
            mem_ack = (memWait == 0);
            memWait = mem_ack ? -1 : memWait - 1;
         end else begin
            mem_ack = ($urandom_range(0, 7) == 0);
            memWait = -1;
         end
         mem_rdata = $urandom;
      end
      if_req = 1'b0; dm_req = 1'b0; mem_ack = 1'b0;
   endtask

   initial begin
      reset = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; mem_ack = 1'b0;
      if_addr = 32'd0; dm_addr = 32'd0; dm_wdata = 32'd0; mem_rdata = 32'd0;
      test_reset();
      test_lone_fetch();
      test_store();
      test_contention();
      test_masking();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", nRun, nFail);
      $finish;
   end

endmodule
